// File: rtl/urv_dm_periph.sv
// urv_dm_periph: data-memory mapped 8N1 UART transmitter with TX FIFO and optional one-shot timer.
// Latency: loads and unblocked stores acknowledge exactly one cycle after the request.
// Backpressure: a TXDATA store into a full FIFO is held pending (no ack) until a slot frees.
// Optional timer: compiled in only when URV_DM_PERIPH_TIMER_EN is defined.
module urv_dm_periph #(
  parameter logic [31:0] g_base       = 32'h00100000,
  parameter int          g_clk_div    = 868,
  parameter int          g_fifo_depth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        irq_o,
  output logic        tx_o
);

  localparam int AW = $clog2(g_fifo_depth);
  localparam int DW = $clog2(g_clk_div);
  localparam logic [AW:0]   FIFO_FULL_CNT = (AW+1)'(g_fifo_depth);
  localparam logic [DW-1:0] DIV_LAST      = DW'(g_clk_div - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Address decode: 16-byte window, word offset selects the register.
  logic       hit, st_hit, ld_hit, tx_wr;
  logic [1:0] off;
  assign hit    = (dm_addr_i[31:4] == g_base[31:4]);
  assign off    = dm_addr_i[3:2];
  assign st_hit = dm_store_i & hit;
  assign ld_hit = dm_load_i & hit;
  assign tx_wr  = st_hit & (off == 2'd0) & dm_data_select_i[0];

  // Byte lanes above 0, upper store data and the byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{dm_addr_i[1:0], dm_data_s_i[31:8], dm_data_select_i[3:1]};

  // TX FIFO state and the single pending-store slot.
  logic [7:0]    fifo_mem [g_fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop, pend;
  logic [7:0]    pend_dat, push_dat;

  // Fullness is taken from the registered count, so a same-cycle pop never frees room early.
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = (tx_wr | pend) & ~fifo_full;
  assign push_dat   = pend ? pend_dat : dm_data_s_i[7:0];

  // FIFO storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_dat;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // UART transmitter: registered state plus combinational next-state logic.
  uart_state_t   state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;

  // tx_o is derived from the next state so the line changes together with the state register.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = fifo_mem[rd_ptr];
          div_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      S_DATA: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      S_STOP: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // UART state register; reset aborts any frame in flight and idles the line high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      tx_o    <= tx_nxt;
    end
  end

  logic [31:0] tmr_rd;

`ifdef URV_DM_PERIPH_TIMER_EN
  logic       tmr_wr, irq_q;
  logic [7:0] tmr_cnt;
  assign tmr_wr = st_hit & (off == 2'd1);

  // One-shot down-counter: a write reloads it, reaching 1 fires a sticky interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_cnt <= '0;
      irq_q   <= 1'b0;
    end else if (tmr_wr) begin
      tmr_cnt <= dm_data_s_i[7:0];
      irq_q   <= 1'b0;
    end else if (tmr_cnt == 8'd1) begin
      tmr_cnt <= '0;
      irq_q   <= 1'b1;
    end else if (tmr_cnt != 8'd0) begin
      tmr_cnt <= tmr_cnt - 8'd1;
    end
  end

  assign irq_o  = irq_q;
  assign tmr_rd = {24'h0, tmr_cnt};
`else
  assign irq_o  = 1'b0;
  assign tmr_rd = '0;
`endif

  // Read data selection by word offset.
  logic [31:0] rd_dat;
  always_comb begin
    rd_dat = '0;
    case (off)
      2'd1:    rd_dat = tmr_rd;
      2'd2:    rd_dat = {29'd0, irq_o, fifo_empty & (state == S_IDLE), fifo_full};
      default: rd_dat = '0;
    endcase
  end

  // Bus responses and the pending TXDATA slot; load data holds between loads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= '0;
      pend            <= 1'b0;
      pend_dat        <= '0;
    end else begin
      dm_load_done_o  <= ld_hit;
      if (ld_hit) dm_data_l_o <= rd_dat;
      dm_store_done_o <= (st_hit & ~(tx_wr & fifo_full)) | (pend & ~fifo_full);
      if (tx_wr & fifo_full) begin
        pend     <= 1'b1;
        pend_dat <= dm_data_s_i[7:0];
      end else if (pend & ~fifo_full) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_urv_dm_periph.sv
// tb_urv_dm_periph: directed bench for urv_dm_periph with g_clk_div=4, g_fifo_depth=4.
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
// Timer expectations follow whether URV_DM_PERIPH_TIMER_EN is defined.
module tb_urv_dm_periph;

  localparam logic [31:0] A_TX  = 32'h00100000;
  localparam logic [31:0] A_TMR = 32'h00100004;
  localparam logic [31:0] A_ST  = 32'h00100008;
  localparam logic [31:0] A_RSV = 32'h0010000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr, dm_data_s, dm_data_l;
  logic [3:0]  dm_sel;
  logic        dm_store, dm_load, store_done, load_done, irq, tx;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] seq_b [6];

  always #5 clk = ~clk;

  urv_dm_periph #(.g_base(32'h00100000), .g_clk_div(4), .g_fifo_depth(4)) dut (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s),
    .dm_data_select_i(dm_sel), .dm_store_i(dm_store), .dm_load_i(dm_load),
    .dm_data_l_o(dm_data_l), .dm_store_done_o(store_done), .dm_load_done_o(load_done),
    .irq_o(irq), .tx_o(tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store_ack(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel, input string tag);
    dm_addr = a; dm_data_s = d; dm_sel = sel; dm_store = 1'b1;
    step();
    dm_store = 1'b0;
    check({tag, "_ack"}, store_done, 1'b1);
  endtask

  task automatic load_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    dm_addr = a; dm_load = 1'b1;
    step();
    dm_load = 1'b0;
    check({tag, "_done"}, load_done, 1'b1);
    check({tag, "_data"}, dm_data_l, exp);
  endtask

  // Checks one 8N1 frame cycle by cycle; skip = frame cycles already elapsed.
  task automatic expect_frame(input logic [7:0] b, input int skip, input int exp_wait, input string tag);
    int w;
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    w = 0;
    if (skip == 0) begin
      while (tx !== 1'b0 && w < 200) begin
        step();
        w++;
      end
      check({tag, "_gap"}, w, exp_wait);
    end
    for (int k = skip; k < 40; k++) begin
      check({tag, "_bit"}, tx, fr[k/4]);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dm_addr = '0; dm_data_s = '0; dm_sel = '0; dm_store = 1'b0; dm_load = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_sdone", store_done, 1'b0);
    check("rst_ldone", load_done, 1'b0);
    check("rst_ldata", dm_data_l, 32'h0);
    rst = 1'b0;
    step();

    // Register reads after reset.
    load_chk(A_ST, 32'h2, "status_idle");
    step();
    check("ldone_pulse", load_done, 1'b0);
    load_chk(A_TX, 32'h0, "rd_txdata");
    load_chk(A_RSV, 32'h0, "rd_rsv");
    load_chk(A_TMR, 32'h0, "rd_tmr_idle");

    // Single byte 0x41.
    store_ack(A_TX, 32'h41, 4'hF, "tx41");
    expect_frame(8'h41, 0, 1, "f41");

    // TXDATA store without lane 0, STATUS and reserved stores: acked, no side effects.
    store_ack(A_TX, 32'h99, 4'b1110, "nolane0");
    step();
    check("nolane0_tx", tx, 1'b1);
    load_chk(A_ST, 32'h2, "nolane0_st");
    store_ack(A_ST, 32'hFFFFFFFF, 4'hF, "wr_status");
    store_ack(A_RSV, 32'hFFFFFFFF, 4'hF, "wr_rsv");
    load_chk(A_ST, 32'h2, "status_after_wr");

    // Primer byte then five stores on consecutive cycles; the fifth finds the FIFO full.
    seq_b[0] = 8'h55; seq_b[1] = 8'hA5; seq_b[2] = 8'h3C;
    seq_b[3] = 8'h0F; seq_b[4] = 8'hF0; seq_b[5] = 8'h81;
    for (int i = 0; i < 6; i++) begin
      dm_addr = A_TX; dm_data_s = {24'h0, seq_b[i]}; dm_sel = 4'hF; dm_store = 1'b1;
      step();
      check("burst_ack", store_done, (i < 5) ? 1'b1 : 1'b0);
    end
    dm_store = 1'b0;
    n = 0;
    while (store_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("pend_ack_delay", n, 38);
    step();
    check("pend_ack_pulse", store_done, 1'b0);
    expect_frame(seq_b[1], 2, 0, "fA");
    expect_frame(seq_b[2], 0, 1, "fB");
    expect_frame(seq_b[3], 0, 1, "fC");
    expect_frame(seq_b[4], 0, 1, "fD");
    expect_frame(seq_b[5], 0, 1, "fE");
    load_chk(A_ST, 32'h2, "status_drained");

    // Accesses outside the window are ignored.
    dm_addr = 32'h0020000C; dm_load = 1'b1;
    step();
    dm_load = 1'b0;
    check("miss_ldone", load_done, 1'b0);
    check("miss_ldata_hold", dm_data_l, 32'h2);
    dm_addr = 32'h00200004; dm_data_s = 32'h1; dm_sel = 4'hF; dm_store = 1'b1;
    step();
    check("miss_sdone_a", store_done, 1'b0);
    dm_addr = 32'h00100010; dm_data_s = 32'h55;
    step();
    dm_store = 1'b0;
    check("miss_sdone_b", store_done, 1'b0);
    repeat (3) step();
    check("miss_tx", tx, 1'b1);
    check("miss_irq", irq, 1'b0);
    load_chk(A_ST, 32'h2, "miss_status");

`ifdef URV_DM_PERIPH_TIMER_EN
    store_ack(A_TMR, 32'h3, 4'hF, "tmr3");
    check("tmr3_irq_c0", irq, 1'b0);
    step();
    check("tmr3_irq_c1", irq, 1'b0);
    step();
    check("tmr3_irq_c2", irq, 1'b0);
    step();
    check("tmr3_irq_c3", irq, 1'b1);
    repeat (4) step();
    check("tmr3_irq_sticky", irq, 1'b1);
    load_chk(A_ST, 32'h6, "status_irq");
    load_chk(A_TMR, 32'h0, "tmr_expired");
    store_ack(A_TMR, 32'h0, 4'hF, "tmr0");
    check("tmr0_clr", irq, 1'b0);
    repeat (5) step();
    check("tmr0_stopped", irq, 1'b0);
    load_chk(A_TMR, 32'h0, "tmr0_rd");
    store_ack(A_TMR, 32'h5, 4'hF, "tmr5");
    load_chk(A_TMR, 32'h5, "tmr5_rd");
    repeat (3) step();
    check("tmr5_irq_lo", irq, 1'b0);
    step();
    check("tmr5_irq_hi", irq, 1'b1);
    store_ack(A_TMR, 32'h1FF, 4'hF, "tmrff");
    check("tmrff_clr", irq, 1'b0);
    load_chk(A_TMR, 32'hFF, "tmrff_rd");
    store_ack(A_TMR, 32'h0, 4'hF, "tmr_stop");
    load_chk(A_ST, 32'h2, "status_tmr_off");
    store_ack(A_TMR, 32'h1, 4'hF, "tmr1");
    step();
    check("tmr1_irq", irq, 1'b1);
`else
    store_ack(A_TMR, 32'h3, 4'hF, "notmr3");
    for (int i = 0; i < 6; i++) begin
      check("notmr_irq", irq, 1'b0);
      step();
    end
    load_chk(A_TMR, 32'h0, "notmr_rd");
    load_chk(A_ST, 32'h2, "notmr_status");
`endif

    // Reset in the middle of DATA bit 3 with another byte queued.
    store_ack(A_TX, 32'h00, 4'hF, "rstf0");
    store_ack(A_TX, 32'h5A, 4'hF, "rstf1");
    repeat (17) step();
    check("pre_rst_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_irq", irq, 1'b0);
    check("rst_async_ldata", dm_data_l, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_tx", tx, 1'b1);
    load_chk(A_ST, 32'h2, "post_rst_status");
    store_ack(A_TX, 32'h41, 4'hF, "post_rst_tx41");
    expect_frame(8'h41, 0, 1, "fpost");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
